// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, entry type and one-hot helper for the write-back queue
package wb_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int DEFAULT_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]     regAddr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [31:0] onehot32(input logic [REG_ADDR_W-1:0] regAddr);
    onehot32 = 32'd1 << regAddr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - result FIFO with an age-ordered entry view (index 0 = head); WBQ_FORWARD_EN adds the data view
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              push,
  input  logic [REG_ADDR_W-1:0]             pushReg,
  input  logic [DATA_W-1:0]                 pushData,
  input  logic                              pop,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DATA_W-1:0]                 headData,
  output logic [DEPTH-1:0]                  ageValid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]  ageReg
`ifdef WBQ_FORWARD_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0]      ageData
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_W-1:0] memReg  [DEPTH];
  logic [DATA_W-1:0]     memData [DEPTH];
  logic [PTR_W-1:0]      headPtr;
  logic [PTR_W-1:0]      tailPtr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PTR_W'(1);
      if (pop)  headPtr <= headPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push) begin
      memReg[tailPtr]  <= pushReg;
      memData[tailPtr] <= pushData;
    end
  end

  assign headData = memData[headPtr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ageValid[i] = CNT_W'(i) < count;
      ageReg[i]   = memReg[headPtr + PTR_W'(i)];
`ifdef WBQ_FORWARD_EN
      ageData[i]  = memData[headPtr + PTR_W'(i)];
`endif
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - buffered register-file write-back with pending mask; WBQ_FORWARD_EN adds forward lookup
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enqValid,
  output logic                  enqReady,
  input  logic [REG_ADDR_W-1:0] enqReg,
  input  logic [DATA_W-1:0]     enqData,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData,
  output logic [31:0]           pendingMask
`ifdef WBQ_FORWARD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwdReg,
  output logic                  fwdHit,
  output logic [DATA_W-1:0]     fwdData
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]                 count;
  logic [DATA_W-1:0]                headData;
  logic [DEPTH-1:0]                 ageValid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ageReg;
`ifdef WBQ_FORWARD_EN
  logic [DEPTH-1:0][DATA_W-1:0]     ageData;
`endif

  logic accept;
  logic storeable;
  logic fifoEmpty;
  logic push;
  logic pop;

  assign enqReady  = reset && (count < CNT_W'(DEPTH));
  assign accept    = enqValid && enqReady;
  assign storeable = accept && (enqReg != '0);
  assign fifoEmpty = (count == '0);
  assign pop       = !fifoEmpty;
  // An empty FIFO hands the new result straight to the output stage.
  assign push      = storeable && !fifoEmpty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushReg  (enqReg),
    .pushData (enqData),
    .pop      (pop),
    .count    (count),
    .headData (headData),
    .ageValid (ageValid),
    .ageReg   (ageReg)
`ifdef WBQ_FORWARD_EN
    ,
    .ageData  (ageData)
`endif
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (!fifoEmpty) begin
      regWrite  <= 1'b1;
      writeReg  <= ageReg[0];
      writeData <= headData;
    end else if (storeable) begin
      regWrite  <= 1'b1;
      writeReg  <= enqReg;
      writeData <= enqData;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  always_comb begin
    pendingMask = regWrite ? onehot32(writeReg) : 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ageValid[i]) pendingMask = pendingMask | onehot32(ageReg[i]);
    end
  end

`ifdef WBQ_FORWARD_EN
  // Oldest candidate first so that each younger match overrides it.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    if (fwdReg != '0) begin
      if (regWrite && (writeReg == fwdReg)) begin
        fwdHit  = 1'b1;
        fwdData = writeData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ageValid[i] && (ageReg[i] == fwdReg)) begin
          fwdHit  = 1'b1;
          fwdData = ageData[i];
        end
      end
    end
  end
`endif

endmodule
